// File: rtl/i2s_rx_pkg.sv
// Shared I2S constants: word-select channel encoding and synchroniser depth.
// The PCM5102 transmit path uses the same channel encoding.
package i2s_rx_pkg;

    typedef enum logic {
        LRCK_LEFT  = 1'b0,
        LRCK_RIGHT = 1'b1
    } i2s_chan_e;

    localparam int unsigned I2S_SYNC_STAGES = 2;

endpackage

// File: rtl/i2s_rx_sync_edge.sv
// N-flop synchroniser for an asynchronous clock-like input, with one extra
// flop so a rising edge of the synchronised level can be flagged.
module sync_edge #(
    parameter int unsigned N = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic rise_o
);

    // [N-1] is the synchronised level, [N] its one-cycle-old copy
    logic [N:0] sr_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sr_q <= '0;
        end else begin
            sr_q <= {sr_q[N-1:0], d_i};
        end
    end

    assign rise_o = sr_q[N-1] & ~sr_q[N];

endmodule

// File: rtl/i2s_rx.sv
// I2S slave receiver: samples BCK/LRCK/DIN in the system clock domain,
// reassembles MSB-first channel words and presents complete L/R pairs.
module i2s_rx
    import i2s_rx_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bck,
    input  logic             lrck,
    input  logic             din,
    output logic [WIDTH-1:0] left,
    output logic [WIDTH-1:0] right,
    output logic             valid
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic                       bck_rise;
    logic [I2S_SYNC_STAGES-1:0] lrck_sync_q;
    logic [I2S_SYNC_STAGES-1:0] din_sync_q;
    logic                       lrck_s;
    logic                       din_s;

    i2s_chan_e        lrck_q, lrck_d;
    logic [WIDTH-1:0] sr_q, sr_d, sr_wr;
    logic [CW-1:0]    cnt_q, cnt_d, cnt_inc;
    logic [WIDTH-1:0] left_hold_q, left_hold_d;
    logic             left_ok_q, left_ok_d;
    logic             synced_q, synced_d;
    logic [WIDTH-1:0] left_q, left_d;
    logic [WIDTH-1:0] right_q, right_d;
    logic             valid_q, valid_d;

    sync_edge #(
        .N(I2S_SYNC_STAGES)
    ) u_bck_sync (
        .clk_i (clk),
        .rst_ni(rst_n),
        .d_i   (bck),
        .rise_o(bck_rise)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lrck_sync_q <= '0;
            din_sync_q  <= '0;
        end else begin
            lrck_sync_q <= {lrck_sync_q[I2S_SYNC_STAGES-2:0], lrck};
            din_sync_q  <= {din_sync_q[I2S_SYNC_STAGES-2:0], din};
        end
    end

    assign lrck_s = lrck_sync_q[I2S_SYNC_STAGES-1];
    assign din_s  = din_sync_q[I2S_SYNC_STAGES-1];

    always_comb begin
        // Current word with this edge's bit placed; a saturated count matches no slot
        sr_wr = sr_q;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (cnt_q == CW'(WIDTH - 1 - i)) begin
                sr_wr[i] = din_s;
            end
        end
        cnt_inc = (cnt_q < CW'(WIDTH)) ? cnt_q + CW'(1) : cnt_q;

        sr_d        = sr_q;
        cnt_d       = cnt_q;
        lrck_d      = lrck_q;
        left_hold_d = left_hold_q;
        left_ok_d   = left_ok_q;
        synced_d    = synced_q;
        left_d      = left_q;
        right_d     = right_q;
        valid_d     = 1'b0;

        if (bck_rise) begin
            if (i2s_chan_e'(lrck_s) != lrck_q) begin
                // Word boundary: this edge's bit is the outgoing word's LSB slot
                if (synced_q) begin
                    if (lrck_q == LRCK_LEFT) begin
                        left_hold_d = sr_wr;
                        left_ok_d   = 1'b1;
                    end else begin
                        if (left_ok_q) begin
                            left_d  = left_hold_q;
                            right_d = sr_wr;
                            valid_d = 1'b1;
                        end
                        left_ok_d = 1'b0;
                    end
                end
                synced_d = 1'b1;
                sr_d     = '0;
                cnt_d    = '0;
                lrck_d   = i2s_chan_e'(lrck_s);
            end else begin
                sr_d  = sr_wr;
                cnt_d = cnt_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr_q        <= '0;
            cnt_q       <= '0;
            lrck_q      <= LRCK_LEFT;
            left_hold_q <= '0;
            left_ok_q   <= 1'b0;
            synced_q    <= 1'b0;
            left_q      <= '0;
            right_q     <= '0;
            valid_q     <= 1'b0;
        end else begin
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            lrck_q      <= lrck_d;
            left_hold_q <= left_hold_d;
            left_ok_q   <= left_ok_d;
            synced_q    <= synced_d;
            left_q      <= left_d;
            right_q     <= right_d;
            valid_q     <= valid_d;
        end
    end

    assign left  = left_q;
    assign right = right_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_i2s_rx.sv
// Directed and randomized bench for i2s_rx: I2S slot streams are generated at
// slot level and expected L/R pairs derived from the slot list alone.
module tb_i2s_rx;

    // Time unit is abstract: clk period 50 units ~ 48 MHz, so 1 unit ~ 0.417 ns
    localparam int CLK_H     = 25;
    localparam int BCK_H_3M  = 391;  // ~3.072 MHz
    localparam int BCK_H_8M  = 150;  // 8 MHz: exactly 3 clk per BCK level

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        bck   = 1'b0;
    logic        lrck  = 1'b0;
    logic        din   = 1'b0;
    logic [15:0] left;
    logic [15:0] right;
    logic        valid;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        bit          chan;
        logic [15:0] word;
        int          len;
    } slot_t;

    slot_t       slots[$];
    logic [15:0] exp_l[$], exp_r[$];
    logic [15:0] cap_l[$], cap_r[$];
    int          hold_viol  = 0;
    int          width_viol = 0;
    bit          prev_valid = 1'b0;
    bit          prev_rst   = 1'b0;
    logic [15:0] prev_l, prev_r;

    i2s_rx #(
        .WIDTH(16)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bck  (bck),
        .lrck (lrck),
        .din  (din),
        .left (left),
        .right(right),
        .valid(valid)
    );

    always #(CLK_H) clk = ~clk;

    // Output monitor: capture every pulse, flag wide pulses and unstrobed changes
    always @(negedge clk) begin
        if (rst_n && prev_rst) begin
            if (valid) begin
                cap_l.push_back(left);
                cap_r.push_back(right);
                if (prev_valid) width_viol++;
            end else if (left !== prev_l || right !== prev_r) begin
                hold_viol++;
            end
        end
        prev_valid = valid;
        prev_l     = left;
        prev_r     = right;
        prev_rst   = rst_n;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [15:0] masked(input logic [15:0] w, input int len);
        logic [15:0] ones = 16'hFFFF;
        if (len >= 16) return w;
        return w & ~(ones >> len);
    endfunction

    task automatic add_slot(input bit chan, input logic [15:0] word, input int len);
        slot_t s;
        s.chan = chan;
        s.word = word;
        s.len  = len;
        slots.push_back(s);
    endtask

    task automatic add_frames(input int n, input logic [15:0] l, input logic [15:0] r, input int len);
        for (int i = 0; i < n; i++) begin
            add_slot(1'b0, l, len);
            add_slot(1'b1, r, len);
        end
    endtask

    // A pair is delivered for an L slot that began at a word boundary (not slot 0),
    // followed by an R slot, followed by any slot whose first edge commits the R word.
    task automatic build_expect();
        for (int i = 1; i + 2 < slots.size(); i++) begin
            if (slots[i].chan == 1'b0 && slots[i+1].chan == 1'b1 && slots[i-1].chan == 1'b1) begin
                exp_l.push_back(masked(slots[i].word, slots[i].len));
                exp_r.push_back(masked(slots[i+1].word, slots[i+1].len));
            end
        end
    endtask

    // Data lags LRCK by one BCK; bits past 16 in a slot are random filler
    task automatic drive_slots(input int bhalf);
        bit prev = 1'b0;
        bit d;
        foreach (slots[s]) begin
            for (int p = 0; p < slots[s].len; p++) begin
                d    = (p < 16) ? slots[s].word[15-p] : 1'($urandom_range(0, 1));
                lrck = slots[s].chan;
                din  = prev;
                prev = d;
                #(bhalf) bck = 1'b1;
                #(bhalf) bck = 1'b0;
            end
        end
    endtask

    task automatic do_reset(input int cycles);
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (cycles) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic new_segment();
        slots.delete();
        exp_l.delete();
        exp_r.delete();
        cap_l.delete();
        cap_r.delete();
        hold_viol  = 0;
        width_viol = 0;
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, ".rst_left"}, left, 0);
        check({name, ".rst_right"}, right, 0);
        check({name, ".rst_valid"}, valid, 0);
    endtask

    task automatic finish_segment(input string name);
        repeat (12) @(posedge clk);
        #1;
        check({name, ".pulses"}, cap_l.size(), exp_l.size());
        for (int i = 0; i < exp_l.size() && i < cap_l.size(); i++) begin
            check($sformatf("%s.left[%0d]", name, i), cap_l[i], exp_l[i]);
            check($sformatf("%s.right[%0d]", name, i), cap_r[i], exp_r[i]);
        end
        check({name, ".hold"}, hold_viol, 0);
        check({name, ".width"}, width_viol, 0);
    endtask

    initial begin
        // T1: 32-BCK slots at 3.072 MHz, first (partial-sync) frame dropped
        new_segment();
        lrck = 1'b0;
        do_reset(3);
        check_reset_outputs("t1");
        add_frames(3, 16'hA5C3, 16'h1234, 32);
        add_slot(1'b0, 16'h0000, 2);
        build_expect();
        drive_slots(BCK_H_3M);
        finish_segment("t1");

        // T2: minimum 16-BCK frames
        new_segment();
        lrck = 1'b0;
        do_reset(2);
        add_frames(3, 16'h8001, 16'h7FFE, 16);
        add_slot(1'b0, 16'h0000, 2);
        build_expect();
        drive_slots(BCK_H_3M);
        finish_segment("t2");

        // T3: 12-BCK short frames, zero-padded LSBs
        new_segment();
        lrck = 1'b0;
        do_reset(2);
        add_frames(3, 16'hABC0, 16'h5A50, 12);
        add_slot(1'b0, 16'h0000, 2);
        build_expect();
        drive_slots(BCK_H_3M);
        finish_segment("t3");

        // T4: continue from T3 state, 1-cycle reset in mid right word
        new_segment();
        add_slot(1'b0, 16'h1111, 32);
        add_slot(1'b1, 16'h2222, 10);
        drive_slots(BCK_H_3M);
        do_reset(1);
        check_reset_outputs("t4");
        slots.delete();
        add_slot(1'b1, 16'h2222, 22);
        add_frames(1, 16'hC3C3, 16'h3C3C, 32);
        add_slot(1'b0, 16'h0000, 2);
        build_expect();
        drive_slots(BCK_H_3M);
        finish_segment("t4");

        // T5: stream begins mid right channel
        new_segment();
        lrck = 1'b1;
        do_reset(2);
        add_slot(1'b1, 16'($urandom), 9);
        add_frames(2, 16'hFFFF, 16'h0000, 32);
        add_slot(1'b0, 16'h0000, 2);
        build_expect();
        drive_slots(BCK_H_3M);
        finish_segment("t5");

        // T6: 100 random frames at 8 MHz, random slot lengths and BCK phase
        new_segment();
        lrck = 1'b0;
        do_reset(2);
        for (int i = 0; i < 100; i++) begin
            add_slot(1'b0, 16'($urandom), int'($urandom_range(32, 16)));
            add_slot(1'b1, 16'($urandom), int'($urandom_range(32, 16)));
        end
        add_slot(1'b0, 16'h0000, 2);
        build_expect();
        #($urandom_range(0, 2 * CLK_H - 1));
        drive_slots(BCK_H_8M);
        finish_segment("t6");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
